// File: rtl/rr_select_encoder_if.sv
// rtl/rr_select_encoder_if.sv - request/grant bundle between requesters, arbiter and decoder
//
// Signals:
//   enable      : arbitration enable (driven by the control side)
//   req[3:0]    : request lines, req[i] requests owner i
//   sel_a       : owner index bit 1 (MSB), decoder input A
//   sel_b       : owner index bit 0 (LSB), decoder input B
//   grant_valid : high while the encoded owner holds the grant
//
// Modports:
//   master : requester/control side, drives enable/req, observes the grant
//   slave  : arbiter side, consumes enable/req, drives the grant

interface rr_select_encoder_if;
    logic       enable;
    logic [3:0] req;
    logic       sel_a;
    logic       sel_b;
    logic       grant_valid;

    modport master (
        output enable,
        output req,
        input  sel_a,
        input  sel_b,
        input  grant_valid
    );

    modport slave (
        input  enable,
        input  req,
        output sel_a,
        output sel_b,
        output grant_valid
    );
endinterface

// File: rtl/rr_select_encoder.sv
// rtl/rr_select_encoder.sv - four-way round-robin arbiter with 2-bit encoded owner
//
// Picks one of four requesters fairly and presents its index as a 2-bit code
// plus a qualifier for a downstream 2-to-4 decoder. Under contention a grant
// is capped at DWELL_MAX cycles; every grant is followed by GAP_CYCLES of
// GAP and one IDLE arbitration cycle, so decoded grants never overlap.
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : rr_select_encoder_if.slave
//           in  enable, req[3:0]
//           out sel_a, sel_b, grant_valid (all registered)

module rr_select_encoder #(
    parameter int unsigned DWELL_MAX  = 8,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rr_select_encoder_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Terminal counter values; dwell saturates here, gap leaves GAP here.
    localparam logic [7:0] DWELL_LAST = 8'(DWELL_MAX - 1);
    localparam logic [3:0] GAP_LAST   = 4'(GAP_CYCLES - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_sel;
    logic [1:0] w_sel_nxt;
    logic [1:0] r_last_owner;
    logic [1:0] w_last_owner_nxt;
    logic [7:0] r_dwell_cnt;
    logic [7:0] w_dwell_cnt_nxt;
    logic [3:0] r_gap_cnt;
    logic [3:0] w_gap_cnt_nxt;
    logic       r_grant_valid;
    logic       w_grant_valid_nxt;

    logic [1:0] w_winner;
    logic [1:0] w_idx;
    logic       w_any_req;
    logic       w_owner_req;
    logic       w_other_req;
    logic       w_cap_hit;
    logic       w_grant_exit;

    // Round-robin scan: last_owner+1 has highest priority, last_owner+0 lowest.
    // The loop walks from lowest to highest priority so the final assignment
    // is the nearest asserted requester after the previous owner.
    always_comb begin
        w_winner = r_last_owner;
        w_idx    = r_last_owner;
        for (int k = 4; k >= 1; k--) begin
            w_idx = r_last_owner + 2'(k);
            if (bus.req[w_idx]) begin
                w_winner = w_idx;
            end
        end
    end

    assign w_any_req   = |bus.req;
    assign w_owner_req = bus.req[r_sel];
    assign w_other_req = |(bus.req & ~(4'b0001 << r_sel));
    assign w_cap_hit   = (r_dwell_cnt == DWELL_LAST);

    // Owner release, enable drop and cap expiry all collapse into one exit.
    assign w_grant_exit = !w_owner_req || !bus.enable || (w_cap_hit && w_other_req);

    always_comb begin
        w_state_nxt       = r_state;
        w_sel_nxt         = r_sel;
        w_last_owner_nxt  = r_last_owner;
        w_dwell_cnt_nxt   = r_dwell_cnt;
        w_gap_cnt_nxt     = r_gap_cnt;
        w_grant_valid_nxt = r_grant_valid;

        case (r_state)
            ST_IDLE: begin
                w_grant_valid_nxt = 1'b0;
                if (bus.enable && w_any_req) begin
                    w_state_nxt       = ST_GRANT;
                    w_sel_nxt         = w_winner;
                    w_last_owner_nxt  = w_winner;
                    w_dwell_cnt_nxt   = 8'd0;
                    w_grant_valid_nxt = 1'b1;
                end
            end

            ST_GRANT: begin
                if (w_grant_exit) begin
                    w_state_nxt       = ST_GAP;
                    w_gap_cnt_nxt     = 4'd0;
                    w_grant_valid_nxt = 1'b0;
                end else if (!w_cap_hit) begin
                    // A sole requester sits at the saturated count forever.
                    w_dwell_cnt_nxt = r_dwell_cnt + 8'd1;
                end
            end

            ST_GAP: begin
                w_grant_valid_nxt = 1'b0;
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + 4'd1;
                end
            end

            default: begin
                w_state_nxt       = ST_IDLE;
                w_grant_valid_nxt = 1'b0;
            end
        endcase
    end

    // last_owner resets to 3 so the first scan starts at owner 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_sel         <= 2'd0;
            r_last_owner  <= 2'd3;
            r_dwell_cnt   <= 8'd0;
            r_gap_cnt     <= 4'd0;
            r_grant_valid <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_sel         <= w_sel_nxt;
            r_last_owner  <= w_last_owner_nxt;
            r_dwell_cnt   <= w_dwell_cnt_nxt;
            r_gap_cnt     <= w_gap_cnt_nxt;
            r_grant_valid <= w_grant_valid_nxt;
        end
    end

    assign bus.sel_a       = r_sel[1];
    assign bus.sel_b       = r_sel[0];
    assign bus.grant_valid = r_grant_valid;

endmodule
